// File: rtl/instruction_mnemonic_emitter.sv
// RV32I mnemonic emitter: decodes an instruction word and streams its
// mnemonic as ASCII bytes plus a delimiter over a valid/ready byte port.
module instruction_mnemonic_emitter #(
    parameter logic [7:0] DELIM_CHAR = 8'h20,
    parameter bit         UPPERCASE  = 1'b0
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        start_in,
    input  logic [31:0] inst_in,
    input  logic        char_ready_in,
    output logic [7:0]  char_out,
    output logic        char_valid,
    output logic        done_flag,
    output logic        error_flag,
    output logic        busy_flag
);

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        EMIT,
        DELIM,
        DONE,
        ERROR
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] inst_q;
    logic [7:0]  buf_q [5];
    logic [2:0]  len_q;
    logic [2:0]  idx_q, idx_d;

    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [39:0] m;
    logic [39:0] dec_str;
    logic [2:0]  dec_len;
    logic        dec_ok;
    logic [7:0]  cur;

    assign opc = inst_q[6:0];
    assign f3  = inst_q[14:12];
    assign f7  = inst_q[31:25];

    // Mnemonic is right-justified in m; an all-zero m marks an undecodable word.
    always_comb begin
        m = '0;
        case (opc)
            7'b0110011: begin
                if (f7 == 7'b0000000) begin
                    case (f3)
                        3'd0: m = {16'h0, "add"};
                        3'd1: m = {16'h0, "sll"};
                        3'd2: m = {16'h0, "slt"};
                        3'd3: m = {8'h0, "sltu"};
                        3'd4: m = {16'h0, "xor"};
                        3'd5: m = {16'h0, "srl"};
                        3'd6: m = {24'h0, "or"};
                        default: m = {16'h0, "and"};
                    endcase
                end else if (f7 == 7'b0100000) begin
                    if (f3 == 3'd0) m = {16'h0, "sub"};
                    else if (f3 == 3'd5) m = {16'h0, "sra"};
                end
            end
            7'b0010011: begin
                case (f3)
                    3'd0: m = {8'h0, "addi"};
                    3'd1: if (f7 == 7'b0000000) m = {8'h0, "slli"};
                    3'd2: m = {8'h0, "slti"};
                    3'd3: m = "sltiu";
                    3'd4: m = {8'h0, "xori"};
                    3'd5: begin
                        if (f7 == 7'b0000000) m = {8'h0, "srli"};
                        else if (f7 == 7'b0100000) m = {8'h0, "srai"};
                    end
                    3'd6: m = {16'h0, "ori"};
                    default: m = {8'h0, "andi"};
                endcase
            end
            7'b0000011: begin
                case (f3)
                    3'd0: m = {24'h0, "lb"};
                    3'd1: m = {24'h0, "lh"};
                    3'd2: m = {24'h0, "lw"};
                    3'd4: m = {16'h0, "lbu"};
                    3'd5: m = {16'h0, "lhu"};
                    default: m = '0;
                endcase
            end
            7'b0100011: begin
                case (f3)
                    3'd0: m = {24'h0, "sb"};
                    3'd1: m = {24'h0, "sh"};
                    3'd2: m = {24'h0, "sw"};
                    default: m = '0;
                endcase
            end
            7'b1100011: begin
                case (f3)
                    3'd0: m = {16'h0, "beq"};
                    3'd1: m = {16'h0, "bne"};
                    3'd4: m = {16'h0, "blt"};
                    3'd5: m = {16'h0, "bge"};
                    3'd6: m = {8'h0, "bltu"};
                    3'd7: m = {8'h0, "bgeu"};
                    default: m = '0;
                endcase
            end
            7'b1101111: m = {16'h0, "jal"};
            7'b1100111: if (f3 == 3'd0) m = {8'h0, "jalr"};
            7'b0110111: m = {16'h0, "lui"};
            7'b0010111: m = "auipc";
            default:    m = '0;
        endcase
    end

    always_comb begin
        dec_len = '0;
        for (int i = 0; i < 5; i++) begin
            if (m[8*i +: 8] != 8'h00) dec_len = dec_len + 3'd1;
        end
    end

    assign dec_ok  = |m;
    assign dec_str = m << {3'd5 - dec_len, 3'b000};

    // The buffer holds lowercase letters only, so case folding is a subtract.
    assign cur = UPPERCASE ? buf_q[idx_q] - 8'h20 : buf_q[idx_q];

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        char_out   = 8'h00;
        char_valid = 1'b0;
        done_flag  = 1'b0;
        error_flag = 1'b0;
        busy_flag  = (state_q != IDLE);
        unique case (state_q)
            IDLE: begin
                idx_d = '0;
                if (start_in) state_d = LOOKUP;
            end
            LOOKUP: begin
                idx_d   = '0;
                state_d = dec_ok ? EMIT : ERROR;
            end
            EMIT: begin
                char_valid = 1'b1;
                char_out   = cur;
                if (char_ready_in) begin
                    if (idx_q == len_q - 3'd1) state_d = DELIM;
                    else idx_d = idx_q + 3'd1;
                end
            end
            DELIM: begin
                char_valid = 1'b1;
                char_out   = DELIM_CHAR;
                if (char_ready_in) state_d = DONE;
            end
            DONE: begin
                done_flag = 1'b1;
                state_d   = IDLE;
            end
            ERROR: begin
                error_flag = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= IDLE;
            inst_q  <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            for (int i = 0; i < 5; i++) buf_q[i] <= 8'h00;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (state_q == IDLE && start_in) inst_q <= inst_in;
            if (state_q == LOOKUP) begin
                len_q <= dec_len;
                for (int i = 0; i < 5; i++) buf_q[i] <= dec_str[8*(4-i) +: 8];
            end
        end
    end

endmodule
